// File: rtl/weight_ser_tx_pkg.sv
// Shared constants and state encoding for the serial weight transmitter.
package weight_ser_tx_pkg;
  localparam int         TX_LENGTH       = 16;
  localparam int         TX_MAX_FEATURES = 15;
  localparam int         TX_IDX_WIDTH    = 4;
  localparam logic [7:0] HDR_TAG         = 8'hA5;

  typedef enum logic [1:0] {IDLE, PRIME, SHIFT, DONE} tx_state_e;
endpackage

// File: rtl/weight_tx_shifter.sv
// LENGTH-bit parallel-in/serial-out register, LSB first, with bit counter
// and flags for the read-ahead point (LENGTH-2) and the last bit (LENGTH-1).
module weight_tx_shifter #(
  parameter int LENGTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [LENGTH-1:0] i_data,
  output logic              o_bit,
  output logic              o_pre_last,
  output logic              o_last
);
  localparam int BW = $clog2(LENGTH);

  logic [LENGTH-1:0] r_sh;
  logic [BW-1:0]     r_cnt;

  // Load restarts the count; shift moves the next bit into position 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sh  <= r_sh >> 1;
      r_cnt <= r_cnt + BW'(1);
    end
  end

  assign o_bit      = r_sh[0];
  assign o_pre_last = (r_cnt == BW'(LENGTH-2));
  assign o_last     = (r_cnt == BW'(LENGTH-1));
endmodule

// File: rtl/weight_ser_tx.sv
// Serial weight transmitter: reads feat+1 words (highest index first) from a
// 1-cycle synchronous memory and shifts them out LSB first with no gaps.
// The next word is read at bit LENGTH-2 so it is loaded exactly at bit LENGTH-1.
// Optional: define WEIGHT_TX_HEADER_EN to prefix the frame with {A5, 0, feat}.
module weight_ser_tx
  import weight_ser_tx_pkg::*;
#(
  parameter int LENGTH       = TX_LENGTH,
  parameter int MAX_FEATURES = TX_MAX_FEATURES,
  parameter int IDX_WIDTH    = TX_IDX_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] feat,
  output logic                 rd_en,
  output logic [IDX_WIDTH-1:0] rd_addr,
  input  logic [LENGTH-1:0]    rd_data,
  output logic                 S_out,
  output logic                 tx_valid,
  output logic                 busy,
  output logic                 done_tx
);
  tx_state_e            r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0] r_widx, r_addr, w_rd_idx, w_feat_cl;
  logic                 w_rd_req, w_load, w_shift, w_latch, w_widx_dec;
  logic                 w_sh_bit, w_pre_last, w_last, w_in_hdr;
  logic [LENGTH-1:0]    w_ld_data;

  // Widen before comparing so the clamp stays meaningful for any IDX_WIDTH.
  assign w_feat_cl = ({1'b0, feat} > (IDX_WIDTH+1)'(MAX_FEATURES)) ?
                     IDX_WIDTH'(MAX_FEATURES) : feat;

`ifdef WEIGHT_TX_HEADER_EN
  logic                 r_hdr;
  logic [IDX_WIDTH-1:0] r_feat_q;

  // Header flag is set for the first word of every frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hdr    <= 1'b0;
      r_feat_q <= '0;
    end else if (w_latch) begin
      r_hdr    <= 1'b1;
      r_feat_q <= w_feat_cl;
    end else if (r_state == SHIFT && w_last) begin
      r_hdr    <= 1'b0;
    end
  end

  assign w_in_hdr  = r_hdr;
  assign w_ld_data = (r_state == PRIME) ?
                     {HDR_TAG, {(LENGTH-8-IDX_WIDTH){1'b0}}, r_feat_q} : rd_data;
`else
  assign w_in_hdr  = 1'b0;
  assign w_ld_data = rd_data;
`endif

  // Next state, read requests and shifter control.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_req    = 1'b0;
    w_rd_idx    = r_widx;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_latch     = 1'b0;
    w_widx_dec  = 1'b0;
    unique case (r_state)
      IDLE: if (start) begin
        w_latch     = 1'b1;
        w_state_nxt = PRIME;
`ifndef WEIGHT_TX_HEADER_EN
        w_rd_req    = 1'b1;
        w_rd_idx    = w_feat_cl;
`endif
      end
      PRIME: begin
        w_load      = 1'b1;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (w_pre_last) begin
          if (w_in_hdr) begin
            w_rd_req = 1'b1;
          end else if (r_widx != '0) begin
            w_rd_req = 1'b1;
            w_rd_idx = r_widx - IDX_WIDTH'(1);
          end
        end
        if (w_last) begin
          w_shift = 1'b0;
          if (w_in_hdr) begin
            w_load = 1'b1;
          end else if (r_widx != '0) begin
            w_load     = 1'b1;
            w_widx_dec = 1'b1;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, word index and last read address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_widx  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch)         r_widx <= w_feat_cl;
      else if (w_widx_dec) r_widx <= r_widx - IDX_WIDTH'(1);
      if (w_rd_req)        r_addr <= w_rd_idx;
    end
  end

  weight_tx_shifter #(.LENGTH(LENGTH)) u_shifter (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_load     (w_load),
    .i_shift    (w_shift),
    .i_data     (w_ld_data),
    .o_bit      (w_sh_bit),
    .o_pre_last (w_pre_last),
    .o_last     (w_last)
  );

  assign rd_en    = w_rd_req & ~RST;
  assign rd_addr  = rd_en ? w_rd_idx : r_addr;
  assign S_out    = (r_state == SHIFT) & w_sh_bit;
  assign tx_valid = (r_state == SHIFT);
  assign busy     = (r_state != IDLE);
  assign done_tx  = (r_state == DONE);
endmodule

// File: tb/tb_weight_ser_tx.sv
// Bench for weight_ser_tx: a frame model builds the expected bit stream from
// the memory contents and compares serial output, timing and read addresses.
module tb_weight_ser_tx;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  feat = '0;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic        S_out, tx_valid, busy, done_tx;

  logic [15:0] mem [16];
  int          rd_log[$];
  int          n_chk = 0;
  int          n_err = 0;

`ifdef WEIGHT_TX_HEADER_EN
  localparam int HDR_EXTRA = 16;
`else
  localparam int HDR_EXTRA = 0;
`endif

  weight_ser_tx dut (
    .CLK(CLK), .RST(RST), .start(start), .feat(feat),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .S_out(S_out), .tx_valid(tx_valid), .busy(busy), .done_tx(done_tx)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read weight memory and read-address log.
  always @(posedge CLK) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
      rd_log.push_back(int'(rd_addr));
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d (0x%0h) exp %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Send one frame and check it against the model; optionally pulse start
  // (with a new feat) while busy after 40 bits.
  task automatic run_frame(input string nm, input int f, input int exp_done, input bit poke);
    bit exp_q[$];
    bit got_q[$];
    int first_c, last_c, done_c, n_done, busy_n, gap, bad_addr;
    bit poked;
`ifdef WEIGHT_TX_HEADER_EN
    logic [15:0] hdr;
    hdr = {8'hA5, 4'h0, 4'(f)};
    for (int b = 0; b < 16; b++) exp_q.push_back(hdr[b]);
`endif
    for (int i = f; i >= 0; i--)
      for (int b = 0; b < 16; b++) exp_q.push_back(mem[i][b]);
    rd_log = {};
    first_c = -1; last_c = -1; done_c = -1;
    n_done = 0; busy_n = 0; gap = 0; poked = 0;
    @(negedge CLK);
    feat  = 4'(f);
    start = 1'b1;
    for (int k = 1; k <= exp_done + 10; k++) begin
      @(negedge CLK);
      start = 1'b0;
      if (tx_valid) begin
        if (first_c < 0) first_c = k;
        else if (last_c != k - 1) gap++;
        last_c = k;
        got_q.push_back(S_out);
      end
      if (done_tx) begin
        n_done++;
        if (done_c < 0) done_c = k;
      end
      if (busy) busy_n++;
      if (poke && !poked && got_q.size() == 40) begin
        start = 1'b1;
        feat  = 4'($urandom);
        poked = 1'b1;
      end
    end
    chk({nm, " first_bit_cycle"}, first_c, 2);
    chk({nm, " bit_count"}, got_q.size(), exp_q.size());
    chk({nm, " gaps"}, gap, 0);
    for (int w = 0; w < exp_q.size() / 16; w++) begin
      logic [15:0] gw, ew;
      for (int b = 0; b < 16; b++) begin
        ew[b] = exp_q[w*16+b];
        gw[b] = (w*16+b < got_q.size()) ? got_q[w*16+b] : 1'b0;
      end
      chk($sformatf("%s word%0d", nm, w), int'(gw), int'(ew));
    end
    chk({nm, " done_cycle"}, done_c, exp_done);
    chk({nm, " done_pulses"}, n_done, 1);
    chk({nm, " busy_cycles"}, busy_n, exp_done);
    chk({nm, " read_count"}, rd_log.size(), f + 1);
    bad_addr = 0;
    for (int j = 0; j < rd_log.size(); j++)
      if (rd_log[j] != f - j) bad_addr++;
    chk({nm, " read_addrs"}, bad_addr, 0);
  endtask

  typedef struct {
    string       nm;
    int          f;
    logic [15:0] m0, m1, m2;
    int          done_c;
    bit          poke;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cnt, bits, hit;
    vecs[0] = '{"three",     2, 16'h0001, 16'h8000, 16'hA5A5,  50, 1'b0};
    vecs[1] = '{"single",    0, 16'hFFFE, 16'h0000, 16'h0000,  18, 1'b0};
    vecs[2] = '{"two",       1, 16'h1234, 16'hABCD, 16'h0000,  34, 1'b0};
    vecs[3] = '{"full_busy", 15, 16'h0F0F, 16'h7FFF, 16'h0101, 258, 1'b1};
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);

    // Reset and idle.
    repeat (5) @(negedge CLK);
    chk("reset rd_addr", int'(rd_addr), 0);
    chk("reset outputs", int'({S_out, tx_valid, busy, done_tx, rd_en}), 0);
    RST = 1'b0;
    cnt = 0;
    rd_log = {};
    repeat (20) begin
      @(negedge CLK);
      if (S_out || tx_valid || busy || rd_en || done_tx) cnt++;
    end
    chk("idle activity", cnt, 0);

    // Start in the same cycle as reset is ignored.
    RST = 1'b1; start = 1'b1; feat = 4'd5;
    @(negedge CLK);
    RST = 1'b0; start = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge CLK);
      if (busy) cnt++;
    end
    chk("start_with_rst busy", cnt, 0);
    chk("start_with_rst reads", rd_log.size(), 0);

    // Directed vectors.
    foreach (vecs[v]) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      mem[0] = vecs[v].m0; mem[1] = vecs[v].m1; mem[2] = vecs[v].m2;
      run_frame(vecs[v].nm, vecs[v].f, vecs[v].done_c + HDR_EXTRA, vecs[v].poke);
    end

    // Mid-frame reset of a feat=3 frame.
    @(negedge CLK);
    feat = 4'd3; start = 1'b1;
    bits = 0; hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge CLK);
      start = 1'b0;
      if (tx_valid) bits++;
      if (bits == 20) hit = 1;
    end
    chk("abort reached bit 20", hit, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort outputs", int'({tx_valid, busy, S_out, done_tx}), 0);
    RST = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (done_tx || busy) cnt++;
    end
    chk("abort no done", cnt, 0);
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    run_frame("after_abort", 3, 2 + 4*16 + HDR_EXTRA, 1'b0);

    // Randomized frames.
    for (int r = 0; r < 6; r++) begin
      int f;
      f = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      run_frame($sformatf("rand%0d", r), f, 2 + (f+1)*16 + HDR_EXTRA, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/weight_ser_tx.md
Name: weight_ser_tx

Overview:
- Serial transmitter for trained model weights; the output-side counterpart of the serial data-load path into `top`.
- Triggered after training completes (`done_`).
- Reads feat+1 16-bit weights from the weight register file through a synchronous read port.
- Shifts them out on one serial line, LSB first, highest index first (index feat down to 0), one bit per CLK, with no gaps between words.

Parameters:
- LENGTH, 16: bits per word.
- MAX_FEATURES, 15: highest legal feat value; sets the read address width.
- IDX_WIDTH, 4: width of feat and rd_addr; must satisfy 2^IDX_WIDTH > MAX_FEATURES.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to transmit a frame; sampled only in IDLE.
- feat  in  IDX_WIDTH  feature count; frame carries feat+1 words; latched when start is accepted.
- rd_en  out  1  weight-memory read strobe.
- rd_addr  out  IDX_WIDTH  weight index to read.
- rd_data  in  LENGTH  weight word; valid in the cycle after rd_en (1-cycle synchronous read).
- S_out  out  1  serial data bit.
- tx_valid  out  1  high in every cycle in which S_out carries a frame bit.
- busy  out  1  high from the cycle after start is accepted until done_tx.
- done_tx  out  1  one-cycle pulse in the cycle after the last frame bit.

Behaviour:
- Reset values (sync RST, highest priority): state=IDLE; S_out=0, tx_valid=0, busy=0, done_tx=0, rd_en=0, rd_addr=0; shift register, bit counter and word index cleared.
- RST asserted mid-frame aborts the frame. Outputs take their reset values on the next edge. No done_tx is produced.
- States and transitions:
  - IDLE: when start=1, latch feat into feat_q, set widx=feat_q, issue rd_en=1 with rd_addr=feat (read of the first word), go to PRIME.
  - PRIME: rd_data is valid. Load it into shift register sh, set bit=0, go to SHIFT.
  - SHIFT: S_out=sh[0], tx_valid=1; sh shifts right each cycle; bit increments.
    - At bit==LENGTH-2, if widx!=0: rd_en=1, rd_addr=widx-1.
    - At bit==LENGTH-1 and widx!=0: load sh from rd_data, set bit=0, widx=widx-1, stay in SHIFT. The next word starts on the following cycle with no gap.
    - At bit==LENGTH-1 and widx==0: go to DONE.
  - DONE: done_tx=1, tx_valid=0, S_out=0; return to IDLE next cycle.
- Latency: start accepted in cycle 0; first bit on S_out in cycle 2; last bit in cycle 1+(feat+1)*LENGTH; done_tx in the cycle after that.
- busy=1 in PRIME, SHIFT and DONE.
- start while busy is ignored, with no queueing. start in the same cycle as RST is ignored.
- feat=0 sends a single word. feat values above MAX_FEATURES are clamped to MAX_FEATURES at latch time.
- rd_en is never asserted outside the two read points above. rd_addr holds its last value when rd_en=0.
- S_out is registered, so there is no combinational path from rd_data to S_out.
- feat changing during a frame has no effect.

Optional Feature:
- Macro: WEIGHT_TX_HEADER_EN.
- Defined: a 16-bit header word is sent LSB first before the weights. Header is {8'hA5, 4'h0, feat_q}.
  - PRIME loads the header instead of rd_data.
  - The first weight read is issued at header bit LENGTH-2.
  - Frame is (feat+2)*LENGTH bits; done_tx moves LENGTH cycles later.
- Not defined: no header; timing exactly as in Behaviour.

Decomposition:
- Shared package:
  - LENGTH, MAX_FEATURES and IDX_WIDTH constants.
  - State encoding enum (IDLE, PRIME, SHIFT, DONE).
  - Header constant 8'hA5.
- One natural sub-module: weight_tx_shifter, holding the LENGTH-bit PISO register, bit counter, and load/last-bit flags.
- The FSM and read sequencing stay in weight_ser_tx.

Test Plan:
1. Reset and idle: RST=1 for 5 cycles, then 0 with no start -> S_out=0, tx_valid=0, busy=0, rd_en=0 for 20 cycles.
2. Three-word frame: feat=2, memory {0:16'h0001, 1:16'h8000, 2:16'hA5A5}, start pulse -> rd_addr sequence 2,1,0.
   - 48 contiguous tx_valid bits: A5A5 LSB-first, then 0x8000, then 0x0001.
   - First bit in cycle 2; done_tx in cycle 50.
3. Single word: feat=0, mem[0]=16'hFFFE -> S_out bits 0,1,1,...,1 (16 bits); exactly one rd_en; done_tx in cycle 18.
4. Start while busy: feat=15, second start pulse at bit 40 -> ignored; exactly 256 bits sent; one done_tx.
5. Mid-frame reset: RST=1 at bit 20 of a feat=3 frame -> next edge gives tx_valid=0, busy=0, S_out=0; no done_tx. A new start afterwards transmits the full frame correctly.
6. With WEIGHT_TX_HEADER_EN: feat=2 -> first 16 bits are 0xA502 LSB-first, followed by the frame from test 2; done_tx in cycle 66.
